// File: rtl/wash_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wash_pkg
//  Brief    : Shared types, default durations and T2 duration selection for
//             the washing-machine dual countdown timer.
//  Options  : WASH_TIMER_PAUSE_EN (used by wash_countdown / wash_timer)
//  Revision : 1.0  initial release
// ============================================================================
package wash_pkg;

  // Timer FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

  // Default durations, in timer ticks
  localparam int unsigned DEF_CNT_W    = 8;
  localparam int unsigned DEF_TICK_DIV = 2;
  localparam int unsigned DEF_T1_TICKS = 4;
  localparam int unsigned DEF_WASH_M   = 6;
  localparam int unsigned DEF_WASH_L   = 10;
  localparam int unsigned DEF_RINSE_M  = 4;
  localparam int unsigned DEF_RINSE_L  = 6;
  localparam int unsigned DEF_DRY_M    = 5;
  localparam int unsigned DEF_DRY_L    = 8;

  // A zero-tick interval would expire on the load edge; treat it as one tick.
  function automatic int unsigned clamp_dur(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

  // Phase priority wash > rinse > dry; large load wins over medium.
  // With no phase flag the interval is a single tick.
  function automatic int unsigned select_t2_dur(
    input logic        wash,
    input logic        rinse,
    input logic        dry,
    input logic        lout,
    input int unsigned wash_m,
    input int unsigned wash_l,
    input int unsigned rinse_m,
    input int unsigned rinse_l,
    input int unsigned dry_m,
    input int unsigned dry_l
  );
    int unsigned d;
    if (wash)       d = lout ? wash_l  : wash_m;
    else if (rinse) d = lout ? rinse_l : rinse_m;
    else if (dry)   d = lout ? dry_l   : dry_m;
    else            d = 1;
    return clamp_dur(d);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wash_countdown.sv
`default_nettype none
// ============================================================================
//  Module   : wash_countdown
//  Brief    : One countdown timer: IDLE/RUN/DONE FSM with tick prescaler and
//             tick counter. Done rises dur*TICK_DIV clocks after the load edge.
//  Options  : WASH_TIMER_PAUSE_EN adds a pause input that freezes counting.
//  Revision : 1.0  initial release
// ============================================================================
module wash_countdown
  import wash_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TICK_DIV = 2
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             start,
  input  logic [CNT_W-1:0] dur,
`ifdef WASH_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             done,
  output logic             busy
);

  localparam int unsigned     PS_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_RELOAD = PS_W'(TICK_DIV - 1);

  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [CNT_W-1:0] w_load_cnt;
  logic             w_freeze;

  // A zero duration must still take one full tick.
  assign w_load_cnt = (dur == '0) ? CNT_W'(1) : dur;

`ifdef WASH_TIMER_PAUSE_EN
  assign w_freeze = pause;
`else
  assign w_freeze = 1'b0;
`endif

  // State, prescaler and counter registers
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ps_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
    end
  end

  // Next-state logic; abort (start low) takes precedence over expiry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ps_d    = ps_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = w_load_cnt;
          ps_d    = PS_RELOAD;
        end
      end
      RUN: begin
        if (!start) begin
          state_d = IDLE;
          cnt_d   = '0;
          ps_d    = '0;
        end else if (w_freeze) begin
          state_d = RUN;
        end else if (ps_q != '0) begin
          ps_d = ps_q - PS_W'(1);
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          ps_d  = PS_RELOAD;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ps_d    = '0;
      end
    endcase
  end

  // Outputs decode the state register only, so they carry no input paths
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
`default_nettype wire

// File: rtl/wash_timer.sv
`default_nettype none
// ============================================================================
//  Module   : wash_timer
//  Brief    : Dual countdown timer for the washing-machine controller.
//             T1 times fixed fill/drain intervals; T2 times phase durations
//             selected by phase and load size at the load edge.
//  Options  : WASH_TIMER_PAUSE_EN adds input pause (freezes running timers).
//  Revision : 1.0  initial release
// ============================================================================
module wash_timer
  import wash_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned T1_TICKS = DEF_T1_TICKS,
  parameter int unsigned WASH_M   = DEF_WASH_M,
  parameter int unsigned WASH_L   = DEF_WASH_L,
  parameter int unsigned RINSE_M  = DEF_RINSE_M,
  parameter int unsigned RINSE_L  = DEF_RINSE_L,
  parameter int unsigned DRY_M    = DEF_DRY_M,
  parameter int unsigned DRY_L    = DEF_DRY_L
) (
  input  logic Clk,
  input  logic nReset,
  input  logic T1start,
  input  logic T2start,
  input  logic Mout,
  input  logic Lout,
  input  logic wash,
  input  logic rinse,
  input  logic dry,
`ifdef WASH_TIMER_PAUSE_EN
  input  logic pause,
`endif
  output logic T1done,
  output logic T2done,
  output logic T1busy,
  output logic T2busy
);

  logic [CNT_W-1:0] w_t1_dur;
  logic [CNT_W-1:0] w_t2_dur;
  logic             w_unused_mout;

  // Medium is the fallback size whenever Lout is clear, so Mout carries no
  // information of its own.
  assign w_unused_mout = Mout;

  assign w_t1_dur = CNT_W'(clamp_dur(T1_TICKS));
  // The countdown latches this only on its load edge, so later flag changes
  // have no effect on a running interval.
  assign w_t2_dur = CNT_W'(select_t2_dur(wash, rinse, dry, Lout,
                                         WASH_M, WASH_L, RINSE_M, RINSE_L,
                                         DRY_M, DRY_L));

  wash_countdown #(
    .CNT_W    (CNT_W),
    .TICK_DIV (TICK_DIV)
  ) u_t1 (
    .Clk    (Clk),
    .nReset (nReset),
    .start  (T1start),
    .dur    (w_t1_dur),
`ifdef WASH_TIMER_PAUSE_EN
    .pause  (pause),
`endif
    .done   (T1done),
    .busy   (T1busy)
  );

  wash_countdown #(
    .CNT_W    (CNT_W),
    .TICK_DIV (TICK_DIV)
  ) u_t2 (
    .Clk    (Clk),
    .nReset (nReset),
    .start  (T2start),
    .dur    (w_t2_dur),
`ifdef WASH_TIMER_PAUSE_EN
    .pause  (pause),
`endif
    .done   (T2done),
    .busy   (T2busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_wash_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wash_timer
//  Brief    : Self-checking bench for wash_timer. A per-timer model counts
//             remaining clocks (ticks * TICK_DIV) from the load edge.
//  Options  : WASH_TIMER_PAUSE_EN enables the pause scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wash_timer;

  localparam int unsigned TD  = 2;
  localparam int unsigned T1D = 4;
  localparam int unsigned WM  = 6;
  localparam int unsigned WL  = 10;
  localparam int unsigned RM  = 4;
  localparam int unsigned RL  = 6;
  localparam int unsigned DM  = 5;
  localparam int unsigned DL  = 8;

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  logic T1start = 1'b0;
  logic T2start = 1'b0;
  logic Mout = 1'b0;
  logic Lout = 1'b0;
  logic wash = 1'b0;
  logic rinse = 1'b0;
  logic dry = 1'b0;
  logic pause = 1'b0;
  logic T1done, T2done, T1busy, T2busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 = waiting, 1 = timing, 2 = expired; rem = clocks left
  int m1_mode = 0, m1_rem = 0;
  int m2_mode = 0, m2_rem = 0;

  wash_timer dut (
    .Clk     (Clk),
    .nReset  (nReset),
    .T1start (T1start),
    .T2start (T2start),
    .Mout    (Mout),
    .Lout    (Lout),
    .wash    (wash),
    .rinse   (rinse),
    .dry     (dry),
`ifdef WASH_TIMER_PAUSE_EN
    .pause   (pause),
`endif
    .T1done  (T1done),
    .T2done  (T2done),
    .T1busy  (T1busy),
    .T2busy  (T2busy)
  );

  always #5 Clk = ~Clk;

  // T2 interval length in clocks from the current phase/size flags
  function automatic int t2_clocks();
    int ticks;
    if (wash)       ticks = Lout ? WL : WM;
    else if (rinse) ticks = Lout ? RL : RM;
    else if (dry)   ticks = Lout ? DL : DM;
    else            ticks = 1;
    if (ticks == 0) ticks = 1;
    return ticks * TD;
  endfunction

  task automatic model_timer(inout int mode, inout int rem, input logic st, input int len);
    case (mode)
      0: if (st) begin mode = 1; rem = len; end
      1: begin
        if (!st) mode = 0;
        else if (!pause) begin
          rem = rem - 1;
          if (rem == 0) mode = 2;
        end
      end
      default: if (!st) mode = 0;
    endcase
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check1("T1busy", T1busy, m1_mode == 1);
    check1("T1done", T1done, m1_mode == 2);
    check1("T2busy", T2busy, m2_mode == 1);
    check1("T2done", T2done, m2_mode == 2);
  endtask

  // Advance one clock, update the model with the inputs seen at the edge,
  // then compare 1 time unit after the edge.
  task automatic step();
    int len2;
    @(posedge Clk);
    len2 = t2_clocks();
    if (nReset) begin
      model_timer(m1_mode, m1_rem, T1start, int'(T1D * TD));
      model_timer(m2_mode, m2_rem, T2start, len2);
    end else begin
      m1_mode = 0;
      m2_mode = 0;
    end
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Assert reset between edges and check that outputs clear immediately
  task automatic async_reset();
    #2;
    nReset = 1'b0;
    #1;
    m1_mode = 0;
    m2_mode = 0;
    check_all();
  endtask

  task automatic release_reset();
    #2;
    nReset = 1'b1;
  endtask

  task automatic set_flags(input logic w, input logic r, input logic d, input logic m, input logic l);
    wash = w; rinse = r; dry = d; Mout = m; Lout = l;
  endtask

  task automatic run_t2(input logic w, input logic r, input logic d, input logic m, input logic l);
    set_flags(w, r, d, m, l);
    T2start = 1'b1;
    steps(23);
    T2start = 1'b0;
    steps(2);
  endtask

  initial begin
    // Reset state
    #1;
    check_all();
    steps(2);
    release_reset();

    // T1 raised at cycle 5: done 8 clocks after load, clears one clock after drop
    steps(5);
    T1start = 1'b1;
    steps(10);
    T1start = 1'b0;
    steps(2);

    // T2 per phase/size: 20, 8, 16, 2 clocks
    run_t2(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_t2(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_t2(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_t2(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Both size flags: large wins
    run_t2(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Abort after 5 clocks, then a fresh full interval; flags change after load
    set_flags(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    T2start = 1'b1;
    steps(5);
    T2start = 1'b0;
    steps(3);
    T2start = 1'b1;
    step();
    set_flags(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    steps(14);
    T2start = 1'b0;
    steps(2);

    // Start drops on the very edge that would expire T1
    T1start = 1'b1;
    steps(8);
    T1start = 1'b0;
    steps(3);

    // Both starts together, T2 wash/medium
    set_flags(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    T1start = 1'b1;
    T2start = 1'b1;
    steps(14);
    T1start = 1'b0;
    T2start = 1'b0;
    steps(2);

    // Reset mid-count, then reload with start still high
    T2start = 1'b1;
    steps(3);
    async_reset();
    steps(2);
    release_reset();
    steps(15);
    T2start = 1'b0;
    steps(2);

`ifdef WASH_TIMER_PAUSE_EN
    // Pause for 3 clocks during a T1 run: 11 clocks in total
    T1start = 1'b1;
    steps(3);
    pause = 1'b1;
    steps(3);
    pause = 1'b0;
    steps(8);
    // Abort while paused
    T1start = 1'b0;
    steps(2);
    T1start = 1'b1;
    steps(2);
    pause = 1'b1;
    steps(2);
    T1start = 1'b0;
    steps(2);
    pause = 1'b0;
    steps(2);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      if (T1start) begin
        if ($urandom_range(23) == 0) T1start = 1'b0;
      end else if ($urandom_range(3) == 0) T1start = 1'b1;
      if (T2start) begin
        if ($urandom_range(27) == 0) T2start = 1'b0;
      end else if ($urandom_range(3) == 0) T2start = 1'b1;
      if ($urandom_range(3) == 0) begin
        wash  = 1'($urandom_range(1));
        rinse = 1'($urandom_range(1));
        dry   = 1'($urandom_range(1));
        Mout  = 1'($urandom_range(1));
        Lout  = 1'($urandom_range(1));
      end
`ifdef WASH_TIMER_PAUSE_EN
      pause = ($urandom_range(7) == 0);
`endif
      if ($urandom_range(249) == 0) begin
        async_reset();
        step();
        release_reset();
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
